// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: one difference bit per clock, LSB first, through a single
// borrow flip-flop, with a start/busy/done handshake.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state;
   logic [WIDTH-1:0] sa, sb, res, res_next;
   logic [CW-1:0]    cnt;
   logic             br, br_next, dbit, abit, bbit;

   always_comb begin
      abit     = sa[0];
      bbit     = sb[0];
      dbit     = abit ^ bbit ^ br;
      br_next  = (~abit & bbit) | (~(abit ^ bbit) & br);
      res_next = res >> 1;
      res_next[WIDTH-1] = dbit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= StIdle;
         busy  <= 1'b0;
         done  <= 1'b0;
         D     <= '0;
         Bout  <= 1'b0;
         sa    <= '0;
         sb    <= '0;
         res   <= '0;
         br    <= 1'b0;
         cnt   <= '0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= A;
                  sb    <= B;
                  br    <= Bin;
                  cnt   <= '0;
                  res   <= '0;
                  busy  <= 1'b1;
                  state <= StRun;
               end else begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end
            end
            StRun: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               br  <= br_next;
               res <= res_next;
               cnt <= cnt + CW'(1);
               // Last bit: publish result on the same edge it is produced
               if (cnt == LastCnt) begin
                  D     <= res_next;
                  Bout  <= br_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StDone;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial full subtractor: the inverse-direction companion to the MUX-built full adder in the arithmetic library. It accepts two WIDTH-bit unsigned operands and a borrow-in, computes one difference bit per clock LSB-first through a single borrow flip-flop, and returns the WIDTH-bit difference and borrow-out with a start/busy/done handshake. It serves area-constrained datapaths that can spend WIDTH cycles per subtraction.

## Interface

Clock is clk; reset is rst, asynchronous and active-high.

**Parameters**
- WIDTH, 8, operand/result width in bits; legal range ≥ 1.

**Ports**
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled on the rising edge only in IDLE or DONE.
- A  input  WIDTH  minuend; captured on the accepted start edge.
- B  input  WIDTH  subtrahend; captured on the accepted start edge.
- Bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; D and Bout are valid from this cycle onward.
- D  output  WIDTH  difference, (A − B − Bin) mod 2^WIDTH.
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).

## Operation

- **Reset:**
  - State goes to IDLE.
  - busy=0, done=0, D=0, Bout=0.
  - Internal shift registers, borrow and counter are cleared.
- **States:** IDLE, RUN, DONE.
- **IDLE, start=1:**
  - Load shift registers sa←A, sb←B.
  - br←Bin, cnt←0, clear the working result register.
  - Go to RUN.
  - start=0 keeps the block in IDLE.
- **RUN, each cycle (one bit per cycle):**
  - a=sa[0], b=sb[0].
  - d = a ^ b ^ br.
  - br ← (~a & b) | (~(a ^ b) & br).
  - Shift d into the MSB of the working result; the working result shifts right.
  - sa and sb shift right by 1.
  - cnt increments.
  - When the WIDTH-th bit is processed, the same edge loads D ← final working result and Bout ← final br, then goes to DONE.
- **DONE:**
  - Lasts one cycle with done=1.
  - Next state is IDLE, or RUN if start=1 in this cycle; that start loads new operands exactly as IDLE does.
- **start during RUN:** ignored; no operand capture, no restart.
- **Output stability:** D and Bout change only on a completion edge or reset. They hold the last result through IDLE and through any later RUN until that run completes.
- **Counter width:** cnt is $clog2(WIDTH+1) bits, so WIDTH=1 still works. That case takes one RUN cycle.

## Timing

- Start accepted at edge k.
  - busy=1 in the cycles between edges k and k+WIDTH.
  - Edge k+WIDTH updates D and Bout and sets done=1.
  - done falls at edge k+WIDTH+1.
- Latency from accepted start to done is WIDTH cycles.
- Throughput: back-to-back operation, with start held high or reasserted in DONE, gives one result every WIDTH+1 cycles.
- busy and done are never high together. done is never high for 2 consecutive cycles unless the run is back-to-back and WIDTH=1… this cannot happen: a DONE is always followed by at least one RUN cycle.
- **Reset mid-RUN:** the operation aborts immediately (asynchronous). All outputs go to 0 with no done pulse. The first edge after rst deasserts sees IDLE.
- Operands A, B and Bin may change freely after the start edge; they are not sampled again.

## Test plan

- **Basic subtract:** reset, then start with A=8'h5A, B=8'h3C, Bin=0.
  - busy high for 8 cycles.
  - done pulses 8 cycles after the start edge.
  - D=8'h1E, Bout=0.
- **Underflow:** A=8'h00, B=8'h01, Bin=0 → D=8'hFF, Bout=1.
- **Borrow-in edge case:** A=8'hFF, B=8'hFF, Bin=1 → D=8'hFF, Bout=1. Also A=8'h10, B=8'h0F, Bin=1 → D=8'h00, Bout=0.
- **Start during RUN:** after A=8'h80, B=8'h01 starts, pulse start with A=8'h00 on the 3rd busy cycle.
  - The run is not disturbed: D=8'h7F, Bout=0, single done pulse.
  - busy falls as normal.
- **Back-to-back:** hold start=1 through the done cycle, with new operands A=8'h03, B=8'h05 presented on that cycle.
  - RUN resumes with busy=1 the cycle after done.
  - Second result is D=8'hFE, Bout=1, done 9 cycles after the first done.
- **Reset mid-operation:** assert rst for one cycle on the 4th busy cycle.
  - busy, done, D and Bout read 0 immediately.
  - No done pulse follows.
  - A fresh start completes correctly.
- **Exhaustive sweep:** WIDTH=4 build, all A, B and Bin combinations → D and Bout match (A−B−Bin) mod 16 and A<B+Bin.
